// File: rtl/extmem_arbiter.sv
// Round-robin arbiter sharing one external-memory port between N_REQ burst
// requesters. A granted burst owns the port until its last beat (writes) or
// its last read return (reads). Read data is tagged with its owner and routed
// back after RD_LAT cycles.
module extmem_arbiter #(
   parameter int unsigned N_REQ  = 3,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LEN_W  = 16,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_we,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*LEN_W-1:0]    req_len,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          beat,
   output logic [N_REQ-1:0]          rd_valid,
   output logic [DATA_W-1:0]         rd_data,
   output logic [N_REQ-1:0]          done,
   output logic                      busy,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_wr_addr,
   output logic [DATA_W-1:0]         mem_wr_data,
   output logic                      mem_re,
   output logic [ADDR_W-1:0]         mem_rd_addr,
   input  logic [DATA_W-1:0]         mem_rd_data
);

   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned DW = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_t;

   state_t              state;
   logic [PW-1:0]       rr_ptr;
   logic [PW-1:0]       owner;
   logic                we_r;
   logic [ADDR_W-1:0]   addr_base;
   logic [LEN_W-1:0]    len;
   logic [LEN_W-1:0]    cnt;
   logic [DW-1:0]       drain_cnt;
   logic [N_REQ-1:0]    done_r;
   // One-hot owner tag per in-flight read; all-zero means no read in that slot.
   logic [N_REQ-1:0]    rd_pipe [RD_LAT];

   logic                gnt_hit;
   logic [PW-1:0]       gnt_idx;
   logic                gnt_we;
   logic [ADDR_W-1:0]   gnt_addr;
   logic [LEN_W-1:0]    gnt_len;
   logic [N_REQ-1:0]    gnt_oh;
   logic [N_REQ-1:0]    owner_oh;
   logic                last_beat;
   logic [ADDR_W-1:0]   beat_addr;

   // Round-robin pick: scan downwards so the first hit after rr_ptr is the last one written.
   always_comb begin
      gnt_hit = 1'b0;
      gnt_idx = '0;
      for (int unsigned k = N_REQ; k >= 1; k--) begin
         if (req_valid[(32'(rr_ptr) + k) % N_REQ]) begin
            gnt_hit = 1'b1;
            gnt_idx = PW'((32'(rr_ptr) + k) % N_REQ);
         end
      end
   end

   assign gnt_we    = req_we[gnt_idx];
   assign gnt_addr  = req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
   assign gnt_len   = req_len[32'(gnt_idx)*LEN_W +: LEN_W];
   assign gnt_oh    = N_REQ'(1) << gnt_idx;
   assign owner_oh  = N_REQ'(1) << owner;
   assign last_beat = (cnt == len - LEN_W'(1));
   // Address wraps naturally modulo 2^ADDR_W.
   assign beat_addr = addr_base + ADDR_W'(cnt);

   // Accept is only offered while idle and out of reset.
   assign req_ready   = (state == StIdle && gnt_hit && rst) ? gnt_oh : '0;
   assign busy        = (state != StIdle);
   assign beat        = (state == StBurst) ? owner_oh : '0;
   assign mem_we      = (state == StBurst) && we_r;
   assign mem_re      = (state == StBurst) && !we_r;
   assign mem_wr_addr = mem_we ? beat_addr : '0;
   assign mem_rd_addr = mem_re ? beat_addr : '0;
   assign mem_wr_data = mem_we ? req_wdata[32'(owner)*DATA_W +: DATA_W] : '0;
   assign rd_valid    = rd_pipe[RD_LAT-1];
   assign rd_data     = mem_rd_data;
   assign done        = done_r;

   // Burst sequencer: arbitration, beat counting, drain and done generation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= StIdle;
         rr_ptr    <= PW'(N_REQ - 1);
         owner     <= '0;
         we_r      <= 1'b0;
         addr_base <= '0;
         len       <= '0;
         cnt       <= '0;
         drain_cnt <= '0;
         done_r    <= '0;
      end else begin
         done_r <= '0;
         unique case (state)
            StIdle: begin
               if (gnt_hit) begin
                  owner     <= gnt_idx;
                  we_r      <= gnt_we;
                  addr_base <= gnt_addr;
                  len       <= gnt_len;
                  cnt       <= '0;
                  rr_ptr    <= gnt_idx;
                  if (gnt_len == '0) begin
                     done_r <= gnt_oh;
                  end else begin
                     state <= StBurst;
                  end
               end
            end
            StBurst: begin
               if (last_beat) begin
                  if (we_r) begin
                     done_r <= owner_oh;
                     state  <= StIdle;
                  end else begin
                     // done must coincide with the final read return.
                     drain_cnt <= DW'(RD_LAT - 1);
                     if (RD_LAT == 1) done_r <= owner_oh;
                     state <= StDrain;
                  end
               end else begin
                  cnt <= cnt + LEN_W'(1);
               end
            end
            StDrain: begin
               if (drain_cnt == '0) begin
                  state <= StIdle;
               end else begin
                  drain_cnt <= drain_cnt - DW'(1);
                  if (drain_cnt == DW'(1)) done_r <= owner_oh;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Read-return tag pipeline, RD_LAT stages deep.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
      end else begin
         rd_pipe[0] <= mem_re ? owner_oh : '0;
         for (int unsigned i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end

endmodule

// File: tb/tb_extmem_arbiter.sv
// Scoreboard bench for extmem_arbiter (default parameters, RD_LAT = 1).
module tb_extmem_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req_valid, req_we, req_ready, beat, rd_valid, done;
   logic [95:0] req_addr;
   logic [47:0] req_len;
   logic [47:0] req_wdata;
   logic [15:0] rd_data, mem_wr_data, mem_rd_data;
   logic        busy, mem_we, mem_re;
   logic [31:0] mem_wr_addr, mem_rd_addr;

   // Per-requester stimulus, packed onto the DUT buses.
   logic        rv [3];
   logic        rwe [3];
   logic [31:0] ra [3];
   logic [15:0] rl [3];
   logic [15:0] wd [3];
   int          wptr [3];
   logic [2:0]  seen_gnt, seen_beat;

   assign req_valid = {rv[2], rv[1], rv[0]};
   assign req_we    = {rwe[2], rwe[1], rwe[0]};
   assign req_addr  = {ra[2], ra[1], ra[0]};
   assign req_len   = {rl[2], rl[1], rl[0]};
   assign req_wdata = {wd[2], wd[1], wd[0]};

   extmem_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_len     (req_len),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .beat        (beat),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .done        (done),
      .busy        (busy),
      .mem_we      (mem_we),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .mem_re      (mem_re),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [15:0] data;
      logic [2:0]  oh;
      int          cyc;
   } ev_t;

   ev_t gnt_q[$];
   ev_t mem_q[$];
   ev_t rd_q[$];
   ev_t done_q[$];

   int n_err = 0;
   int n_chk = 0;
   int cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] pat(int i, int b);
      return 16'(32'hA000 + i * 256 + b);
   endfunction

   function automatic logic [15:0] rd_exp(logic [31:0] a);
      return a[15:0] ^ 16'h5A5A;
   endfunction

   // Memory model: one-cycle read latency, data derived from address.
   always @(posedge clk or negedge rst) begin
      if (!rst) mem_rd_data <= '0;
      else      mem_rd_data <= mem_re ? rd_exp(mem_rd_addr) : 16'h0;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Expected events for a burst granted in idle cycle g; returns next idle cycle.
   function automatic int plan(int i, logic we, logic [31:0] addr, int len, int g);
      ev_t e;
      e.we   = we;
      e.addr = '0;
      e.data = '0;
      e.oh   = 3'(1 << i);
      e.cyc  = g;
      gnt_q.push_back(e);
      for (int b = 0; b < len; b++) begin
         e.addr = addr + 32'(b);
         e.data = we ? pat(i, b) : 16'h0;
         e.cyc  = g + 1 + b;
         mem_q.push_back(e);
         if (!we) begin
            e.data = rd_exp(e.addr);
            e.cyc  = g + 2 + b;
            rd_q.push_back(e);
         end
      end
      e.cyc = g + len + 1;
      done_q.push_back(e);
      if (len == 0) return g + 1;
      if (we) return g + len + 1;
      return g + len + 2;
   endfunction

   // Write-data source: each requester advances its word after every beat.
   initial begin
      for (int i = 0; i < 3; i++) begin
         wptr[i] = 0;
         wd[i]   = pat(i, 0);
      end
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) begin
            if (seen_gnt[i]) wptr[i] = 0;
            else if (seen_beat[i]) wptr[i]++;
            wd[i] = pat(i, wptr[i]);
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT produces an output event.
   initial begin
      ev_t e;
      seen_gnt  = '0;
      seen_beat = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            seen_gnt  = '0;
            seen_beat = '0;
            check("rst_ctrl", 64'({req_ready, beat, rd_valid, done, busy, mem_we, mem_re}), 64'(0));
            check("rst_addr", {mem_wr_addr, mem_rd_addr}, 64'(0));
            check("rst_data", 64'({mem_wr_data, rd_data}), 64'(0));
         end else begin
            seen_gnt  = req_ready;
            seen_beat = beat;
            check("we_re_excl", 64'(mem_we & mem_re), 64'(0));
            if (req_ready != 3'b0) begin
               if (gnt_q.size() > 0) begin
                  e = gnt_q.pop_front();
                  check("gnt_owner", 64'(req_ready), 64'(e.oh));
                  check("gnt_cyc", 64'(cyc), 64'(e.cyc));
               end else check("gnt_extra", 64'(req_ready), 64'(0));
            end
            if (mem_we || mem_re) begin
               if (mem_q.size() > 0) begin
                  e = mem_q.pop_front();
                  check("mem_we", 64'(mem_we), 64'(e.we));
                  check("mem_addr", 64'(mem_we ? mem_wr_addr : mem_rd_addr), 64'(e.addr));
                  if (e.we) check("mem_wdata", 64'(mem_wr_data), 64'(e.data));
                  check("beat", 64'(beat), 64'(e.oh));
                  check("mem_cyc", 64'(cyc), 64'(e.cyc));
               end else check("mem_extra", 64'({mem_we, mem_re}), 64'(0));
            end
            if (rd_valid != 3'b0) begin
               if (rd_q.size() > 0) begin
                  e = rd_q.pop_front();
                  check("rd_valid", 64'(rd_valid), 64'(e.oh));
                  check("rd_data", 64'(rd_data), 64'(e.data));
                  check("rd_cyc", 64'(cyc), 64'(e.cyc));
               end else check("rd_extra", 64'(rd_valid), 64'(0));
            end
            if (done != 3'b0) begin
               if (done_q.size() > 0) begin
                  e = done_q.pop_front();
                  check("done", 64'(done), 64'(e.oh));
                  check("done_cyc", 64'(cyc), 64'(e.cyc));
               end else check("done_extra", 64'(done), 64'(0));
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) rv[i] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic sync(output int k);
      @(posedge clk);
      #1;
      k = cyc;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Hold a request until accepted (bounded), then drop it on the next cycle.
   task automatic request(input int i, input logic we, input logic [31:0] addr, input int len);
      logic got;
      got    = 1'b0;
      rwe[i] = we;
      ra[i]  = addr;
      rl[i]  = 16'(len);
      rv[i]  = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (req_ready[i]) begin
            got = 1'b1;
            break;
         end
      end
      check("gnt_seen", 64'(got), 64'(1));
      @(posedge clk);
      #1;
      rv[i] = 1'b0;
   endtask

   task automatic check_empty(input string tag);
      check(tag, 64'(gnt_q.size() + mem_q.size() + rd_q.size() + done_q.size()), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

   initial begin
      int k, nx, g1, g2, g3;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rv[i]  = 1'b0;
         rwe[i] = 1'b0;
         ra[i]  = '0;
         rl[i]  = '0;
      end
      do_reset();

      // Write burst, requester 1.
      sync(k);
      nx = plan(1, 1'b1, 32'h100, 4, k);
      request(1, 1'b1, 32'h100, 4);
      wait_until(nx + 2);
      check_empty("t1_left");

      // Read burst, requester 0.
      sync(k);
      nx = plan(0, 1'b0, 32'h20, 3, k);
      request(0, 1'b0, 32'h20, 3);
      wait_until(nx + 2);
      check_empty("t2_left");

      // Simultaneous requests after reset, plus a re-request from 0 mid-burst.
      do_reset();
      sync(k);
      g1 = plan(0, 1'b1, 32'h300, 2, k);
      g2 = plan(1, 1'b0, 32'h400, 2, g1);
      g3 = plan(2, 1'b1, 32'h500, 3, g2);
      nx = plan(0, 1'b0, 32'h600, 1, g3);
      fork
         begin
            request(0, 1'b1, 32'h300, 2);
            wait_until(g2 + 1);
            request(0, 1'b0, 32'h600, 1);
         end
         request(1, 1'b0, 32'h400, 2);
         request(2, 1'b1, 32'h500, 3);
      join
      wait_until(nx + 2);
      check_empty("t3_left");

      // Zero-length burst.
      sync(k);
      nx = plan(2, 1'b1, 32'h700, 0, k);
      request(2, 1'b1, 32'h700, 0);
      wait_until(nx + 2);
      check_empty("t4_left");

      // Address wrap.
      sync(k);
      nx = plan(1, 1'b1, 32'hFFFF_FFFF, 3, k);
      request(1, 1'b1, 32'hFFFF_FFFF, 3);
      wait_until(nx + 2);
      check_empty("t5_left");

      // Reset during the second beat of a long read.
      sync(k);
      begin
         ev_t e;
         e.we   = 1'b0;
         e.addr = '0;
         e.data = '0;
         e.oh   = 3'b001;
         e.cyc  = k;
         gnt_q.push_back(e);
         e.addr = 32'h40;
         e.cyc  = k + 1;
         mem_q.push_back(e);
      end
      request(0, 1'b0, 32'h40, 8);
      @(posedge clk);
      #1;
      do_reset();
      repeat (6) @(posedge clk);
      #1;
      check_empty("t6_left");
      sync(k);
      g1 = plan(0, 1'b1, 32'h800, 1, k);
      g2 = plan(1, 1'b1, 32'h900, 1, g1);
      nx = plan(2, 1'b1, 32'hA00, 1, g2);
      fork
         request(0, 1'b1, 32'h800, 1);
         request(1, 1'b1, 32'h900, 1);
         request(2, 1'b1, 32'hA00, 1);
      join
      wait_until(nx + 2);
      check_empty("t6b_left");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
